// File: rtl/pixel_proc_pkg.sv
// Shared encodings for the pixel-stream controller: status states, DSP
// parameter words and the colour codes driven on the colour output.
package pixel_proc_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } status_e;

  localparam logic [7:0] PARAM1 = 8'b01101101;
  localparam logic [7:0] PARAM2 = 8'b11001101;
  localparam logic [7:0] PARAM3 = 8'b00010111;

  localparam logic [1:0] COLOUR_RED    = 2'b00;
  localparam logic [1:0] COLOUR_GREEN  = 2'b01;
  localparam logic [1:0] COLOUR_BLUE   = 2'b10;
  localparam logic [1:0] COLOUR_YELLOW = 2'b11;

  function automatic logic [7:0] param_sel(input logic force_p1, input status_e st);
    if (force_p1) begin
      return PARAM1;
    end else if (st == GREEN) begin
      return PARAM2;
    end else begin
      return PARAM3;
    end
  endfunction

  function automatic logic [1:0] colour_of(input status_e st);
    case (st)
      RED:     return COLOUR_RED;
      GREEN:   return COLOUR_GREEN;
      BLUE:    return COLOUR_BLUE;
      YELLOW:  return COLOUR_YELLOW;
      default: return COLOUR_RED;
    endcase
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO with flush; the head word reads as zero while
// empty so downstream never sees stale storage.
module pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;

  assign full  = (level_r == (AW+1)'(DEPTH));
  assign empty = (level_r == (AW+1)'(0));
  assign level = level_r;
  assign rdata = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; flush discards any same-cycle push/pop.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array, intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/pixel_proc_ctrl.sv
// Frame sequencer: status FSM, beat counter, per-channel XOR scramble into
// the output FIFO, DSP parameter mux and registered status colour.
module pixel_proc_ctrl
  import pixel_proc_pkg::*;
#(
  parameter int                PIX_W     = 8,
  parameter int                CH        = 1,
  parameter int                DEPTH     = 4,
  parameter int                FRAME_LEN = 16,
  parameter logic [PIX_W-1:0]  XOR_MASK  = PIX_W'(8'hCC)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      abort,
  input  logic                      pix_req,
  input  logic                      start_dec,
  // "config" is a reserved word, hence config_sel
  input  logic                      config_sel,
  input  logic [7:0]                a,
  input  logic [7:0]                b,
  input  logic [CH*PIX_W-1:0]       pixel_in,
  input  logic                      pixel_in_valid,
  output logic                      pixel_in_ready,
  output logic [CH*PIX_W-1:0]       pixel_out,
  output logic                      pixel_out_valid,
  input  logic                      pixel_out_ready,
  output logic [7:0]                param,
  output logic [1:0]                status,
  output logic [1:0]                colour,
  output logic                      start,
  output logic                      frame_done,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int BW = CH * PIX_W;
  localparam int CW = $clog2(FRAME_LEN + 1);

  status_e          state_r, state_s;
  logic             start_r, start_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             frame_done_r, frame_done_s;
  logic [1:0]       colour_r;
  logic [BW-1:0]    wdata_s;
  logic             full_s, empty_s, push_s, pop_s, last_beat_s;
  logic             unused_s;

  assign unused_s = ^{a[7:4], a[1:0], b[7:6], b[4:0]};

  assign pixel_in_ready  = (state_r == BLUE) && !full_s;
  assign push_s          = pixel_in_valid && pixel_in_ready;
  assign pixel_out_valid = !empty_s;
  assign pop_s           = pixel_out_valid && pixel_out_ready;
  assign last_beat_s     = push_s && (cnt_r == CW'(FRAME_LEN - 1));

  assign status     = state_r;
  assign colour     = colour_r;
  assign start      = start_r;
  assign frame_done = frame_done_r;
  assign param      = param_sel(config_sel, state_r);

  // Per-channel scramble; channels never interact.
  always_comb begin
    wdata_s = {BW{1'b0}};
    for (int i = 0; i < CH; i++) begin
      wdata_s[i*PIX_W +: PIX_W] = pixel_in[i*PIX_W +: PIX_W] ^ XOR_MASK;
    end
  end

  pixel_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (abort),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (pixel_out),
    .full  (full_s),
    .empty (empty_s),
    .level (fifo_level)
  );

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_s      = state_r;
    start_s      = start_r;
    cnt_s        = cnt_r;
    frame_done_s = 1'b0;
    if (abort) begin
      state_s = RED;
      start_s = 1'b0;
      cnt_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        RED: begin
          if (pix_req) state_s = GREEN;
          else         state_s = RED;
        end
        GREEN: begin
          if (a[3]) begin
            state_s = BLUE;
            start_s = start_dec;
            cnt_s   = {CW{1'b0}};
          end else if ({b[5], a[3:2]} == 3'b001) begin
            state_s = YELLOW;
          end else begin
            state_s = GREEN;
          end
        end
        BLUE: begin
          if (push_s) begin
            cnt_s = cnt_r + CW'(1);
            if (last_beat_s) begin
              state_s      = YELLOW;
              frame_done_s = 1'b1;
            end else begin
              state_s = BLUE;
            end
          end else begin
            state_s = BLUE;
          end
        end
        YELLOW: begin
          if (empty_s) begin
            state_s = RED;
            start_s = 1'b0;
          end else begin
            state_s = YELLOW;
          end
        end
        default: state_s = RED;
      endcase
    end
  end

  // Control registers; colour samples the pre-edge status so it lags by one.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_r      <= RED;
      start_r      <= 1'b0;
      cnt_r        <= {CW{1'b0}};
      frame_done_r <= 1'b0;
      colour_r     <= COLOUR_RED;
    end else begin
      state_r      <= state_s;
      start_r      <= start_s;
      cnt_r        <= cnt_s;
      frame_done_r <= frame_done_s;
      colour_r     <= colour_of(state_r);
    end
  end

endmodule

// File: tb/tb_pixel_proc_ctrl.sv
// Directed bench: a 2-channel, 4-beat-frame instance for frame/abort/reset
// scenarios and a 1-channel, 8-beat-frame instance for sink back-pressure.
module tb_pixel_proc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, abort, pix_req, start_dec, config_sel;
  logic [7:0]  a, b;
  logic [15:0] pixel_in;
  logic        pixel_in_valid, pixel_out_ready;
  logic        pixel_in_ready, pixel_out_valid, start, frame_done;
  logic [15:0] pixel_out;
  logic [7:0]  param;
  logic [1:0]  status, colour;
  logic [2:0]  fifo_level;

  logic        abort2, pix_req2, start_dec2, config2;
  logic [7:0]  a2, b2, pixel_in2;
  logic        valid2, out_ready2;
  logic        in_ready2, out_valid2, start2, frame_done2;
  logic [7:0]  pixel_out2, param2;
  logic [1:0]  status2, colour2;
  logic [2:0]  level2;

  int vecs = 0;
  int errs = 0;

  logic [15:0] beats [4] = '{16'h00FF, 16'h1234, 16'hCCCC, 16'hAAAA};
  logic [15:0] outs  [4] = '{16'hCC33, 16'hDEF8, 16'h0000, 16'h6666};

  pixel_proc_ctrl #(.PIX_W(8), .CH(2), .DEPTH(4), .FRAME_LEN(4)) u_dut (
    .clk(clk), .rstn(rstn), .abort(abort), .pix_req(pix_req),
    .start_dec(start_dec), .config_sel(config_sel), .a(a), .b(b),
    .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
    .pixel_in_ready(pixel_in_ready), .pixel_out(pixel_out),
    .pixel_out_valid(pixel_out_valid), .pixel_out_ready(pixel_out_ready),
    .param(param), .status(status), .colour(colour), .start(start),
    .frame_done(frame_done), .fifo_level(fifo_level)
  );

  pixel_proc_ctrl #(.PIX_W(8), .CH(1), .DEPTH(4), .FRAME_LEN(8)) u_dut2 (
    .clk(clk), .rstn(rstn), .abort(abort2), .pix_req(pix_req2),
    .start_dec(start_dec2), .config_sel(config2), .a(a2), .b(b2),
    .pixel_in(pixel_in2), .pixel_in_valid(valid2),
    .pixel_in_ready(in_ready2), .pixel_out(pixel_out2),
    .pixel_out_valid(out_valid2), .pixel_out_ready(out_ready2),
    .param(param2), .status(status2), .colour(colour2), .start(start2),
    .frame_done(frame_done2), .fifo_level(level2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b1; abort = 1'b0; pix_req = 1'b0; start_dec = 1'b0; config_sel = 1'b0;
    a = 8'h00; b = 8'h00; pixel_in = 16'h0000; pixel_in_valid = 1'b0; pixel_out_ready = 1'b1;
    abort2 = 1'b0; pix_req2 = 1'b0; start_dec2 = 1'b0; config2 = 1'b0;
    a2 = 8'h00; b2 = 8'h00; pixel_in2 = 8'h00; valid2 = 1'b0; out_ready2 = 1'b0;

    // reset state
    #12;
    chk("rst_status", status, 2'd0);
    chk("rst_colour", colour, 2'd0);
    chk("rst_start", start, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_pixel_out", pixel_out, 16'h0000);
    chk("rst_out_valid", pixel_out_valid, 1'b0);
    chk("rst_in_ready", pixel_in_ready, 1'b0);
    chk("param_red", param, 8'h17);
    config_sel = 1'b1; #1;
    chk("param_cfg_red", param, 8'h6D);
    config_sel = 1'b0;
    rstn = 1'b0;

    // full frame, sink always ready
    pix_req = 1'b1; tick;
    chk("f_status_green", status, 2'd1);
    chk("f_param_green", param, 8'hCD);
    chk("f_colour_lag", colour, 2'd0);
    pix_req = 1'b0; a = 8'h08; start_dec = 1'b1; tick;
    chk("f_status_blue", status, 2'd2);
    chk("f_start", start, 1'b1);
    chk("f_colour_green", colour, 2'd1);
    chk("f_in_ready", pixel_in_ready, 1'b1);
    a = 8'h00; start_dec = 1'b0; config_sel = 1'b1; #1;
    chk("param_cfg_blue", param, 8'h6D);
    config_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pixel_in = beats[i]; pixel_in_valid = 1'b1; tick;
      chk("f_pixel_out", pixel_out, outs[i]);
      chk("f_out_valid", pixel_out_valid, 1'b1);
      chk("f_level", fifo_level, 3'd1);
      chk("f_frame_done", frame_done, (i == 3) ? 1'b1 : 1'b0);
    end
    pixel_in_valid = 1'b0;
    chk("f_status_yellow", status, 2'd3);
    chk("f_ready_drop", pixel_in_ready, 1'b0);
    tick;
    chk("f_done_pulse_end", frame_done, 1'b0);
    chk("f_drain_level", fifo_level, 3'd0);
    chk("f_drain_valid", pixel_out_valid, 1'b0);
    tick;
    chk("f_status_red", status, 2'd0);
    chk("f_start_clear", start, 1'b0);

    // GREEN -> YELLOW -> RED without any accepts
    pix_req = 1'b1; tick;
    pix_req = 1'b0; a = 8'h04; b = 8'h00; start_dec = 1'b1; pixel_in_valid = 1'b1; tick;
    chk("y_status_yellow", status, 2'd3);
    chk("y_start", start, 1'b0);
    chk("y_in_ready", pixel_in_ready, 1'b0);
    tick;
    chk("y_status_red", status, 2'd0);
    chk("y_level", fifo_level, 3'd0);
    a = 8'h00; start_dec = 1'b0; pixel_in_valid = 1'b0;

    // abort in BLUE with level 3 and a simultaneous accept
    pix_req = 1'b1; tick;
    pix_req = 1'b0; a = 8'h08; start_dec = 1'b1; tick;
    a = 8'h00; start_dec = 1'b0; pixel_out_ready = 1'b0;
    pixel_in = 16'h1111; pixel_in_valid = 1'b1;
    tick; tick; tick;
    chk("a_level3", fifo_level, 3'd3);
    chk("a_status_blue", status, 2'd2);
    abort = 1'b1; #1;
    chk("a_accept_pending", pixel_in_ready, 1'b1);
    tick;
    chk("a_status", status, 2'd0);
    chk("a_level", fifo_level, 3'd0);
    chk("a_out_valid", pixel_out_valid, 1'b0);
    chk("a_pixel_out", pixel_out, 16'h0000);
    chk("a_start", start, 1'b0);
    chk("a_colour_blue", colour, 2'd2);
    abort = 1'b0; pixel_in_valid = 1'b0; pixel_out_ready = 1'b1;
    tick;
    chk("a_colour_red", colour, 2'd0);
    chk("a_status_hold", status, 2'd0);

    // back-pressure on the 8-beat instance
    pix_req2 = 1'b1; tick;
    pix_req2 = 1'b0; a2 = 8'h08; tick;
    chk("s_status_blue", status2, 2'd2);
    a2 = 8'h00; out_ready2 = 1'b0; valid2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pixel_in2 = 8'(8'h10 + k); tick;
    end
    chk("s_level_full", level2, 3'd4);
    chk("s_in_ready_full", in_ready2, 1'b0);
    chk("s_head", pixel_out2, 8'hDC);
    pixel_in2 = 8'h14; tick;
    chk("s_level_hold", level2, 3'd4);
    chk("s_head_hold", pixel_out2, 8'hDC);
    out_ready2 = 1'b1; tick;
    chk("s_pop1", pixel_out2, 8'hDD);
    chk("s_pop1_level", level2, 3'd3);
    chk("s_pop1_ready", in_ready2, 1'b1);
    tick;
    chk("s_pop2", pixel_out2, 8'hDE);
    chk("s_fifth_in", level2, 3'd3);
    valid2 = 1'b0; tick;
    chk("s_pop3", pixel_out2, 8'hDF);
    tick;
    chk("s_pop4", pixel_out2, 8'hD8);
    chk("s_pop4_level", level2, 3'd1);
    tick;
    chk("s_empty", out_valid2, 1'b0);
    chk("s_still_blue", status2, 2'd2);

    // asynchronous reset mid-frame with level 2
    pix_req = 1'b1; tick;
    pix_req = 1'b0; a = 8'h08; start_dec = 1'b1; tick;
    a = 8'h00; start_dec = 1'b0; pixel_out_ready = 1'b0;
    pixel_in = 16'h5A5A; pixel_in_valid = 1'b1;
    tick; tick;
    chk("r_level2", fifo_level, 3'd2);
    chk("r_start_pre", start, 1'b1);
    #2; rstn = 1'b1; #1;
    chk("r_status", status, 2'd0);
    chk("r_colour", colour, 2'd0);
    chk("r_start", start, 1'b0);
    chk("r_level", fifo_level, 3'd0);
    chk("r_out_valid", pixel_out_valid, 1'b0);
    chk("r_pixel_out", pixel_out, 16'h0000);
    chk("r_in_ready", pixel_in_ready, 1'b0);
    chk("r_frame_done", frame_done, 1'b0);
    pixel_in_valid = 1'b0;
    rstn = 1'b0;
    tick;
    chk("r_after", status, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
